alu_seq: RTL and testbench

Clocked, parametrised successor to the combinational 8-bit ALU of the elementary CPU datapath. It keeps the existing op encoding and the C/Z flags, and adds four things: a WIDTH parameter, a start/busy/done handshake, held result and flag registers, and new ops. Single-cycle ops are ADC and OR. Multi-cycle ops are barrel-free shifts (one bit per cycle) and a shift-add multiply. It sits between the register file read ports and the write-back mux, and the control unit stalls on busy.

---
 rtl/alu_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Clocked ALU with start/busy/done handshake: single-cycle arithmetic/logic ops,
// bit-serial shifts (one bit per cycle) and a shift-add multiplier.
module alu_seq #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             M,
   input  logic [3:0]       se,
   input  logic [WIDTH-1:0] S,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] T,
   output logic             Cf,
   output logic             Zf,
   output logic             busy,
   output logic             done
);

   localparam int CW = SHW + 1;

   localparam logic [3:0] OP_ADC    = 4'b0001;
   localparam logic [3:0] OP_SHL    = 4'b0010;
   localparam logic [3:0] OP_SHR    = 4'b0011;
   localparam logic [3:0] OP_PASSD0 = 4'b0100;
   localparam logic [3:0] OP_NOT    = 4'b0101;
   localparam logic [3:0] OP_SUB    = 4'b0110;
   localparam logic [3:0] OP_MUL    = 4'b0111;
   localparam logic [3:0] OP_OR     = 4'b1000;
   localparam logic [3:0] OP_ADD    = 4'b1001;
   localparam logic [3:0] OP_PASSD1 = 4'b1010;
   localparam logic [3:0] OP_AND    = 4'b1011;
   localparam logic [3:0] OP_PASSS  = 4'b1100;

   typedef enum logic {ST_IDLE, ST_RUN} state_e;
   typedef enum logic [1:0] {MOP_SHL, MOP_SHR, MOP_MUL} mop_e;

   state_e                 state_q, state_d;
   mop_e                   mop_q, mop_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [WIDTH-1:0]       work_q, work_d;
   logic                   sh_cf_q, sh_cf_d;
   logic [2*WIDTH-1:0]     prod_q, prod_d;
   logic [2*WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]       t_q, t_d;
   logic                   cf_q, cf_d;
   logic                   zf_q, zf_d;
   logic                   done_q, done_d;

   logic [SHW-1:0]         shamt;
   logic [WIDTH:0]         sum;
   logic [WIDTH-1:0]       sc_t;
   logic                   sc_cf;
   logic                   sc_zf;
   logic                   sc_zf_ok;
   logic                   sc_multi;

   logic [WIDTH-1:0]       step_work;
   logic                   step_cf;
   logic [2*WIDTH-1:0]     step_prod;
   logic [WIDTH-1:0]       fin_t;
   logic                   fin_cf;

   assign shamt = S[SHW-1:0];

   // Result of a single-cycle op from the operands presented at the accept edge.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path infers a latch.
      sc_t     = '0;
      sc_cf    = 1'b0;
      sc_zf_ok = 1'b1;
      sc_multi = 1'b0;
      sum      = '0;
      if (!M) begin
         sc_t = S;
      end else begin
         case (se)
            OP_ADD: begin
               sum           = {1'b0, S} + {1'b0, D};
               {sc_cf, sc_t} = sum;
            end
            OP_SUB: begin
               sum           = {1'b0, D} - {1'b0, S};
               {sc_cf, sc_t} = sum;
            end
            OP_ADC: begin
               sum           = {1'b0, S} + {1'b0, D} + {{WIDTH{1'b0}}, cf_q};
               {sc_cf, sc_t} = sum;
            end
            OP_AND:               sc_t = S & D;
            OP_OR:                sc_t = S | D;
            OP_NOT:               sc_t = ~D;
            OP_PASSD0, OP_PASSD1: sc_t = D;
            OP_PASSS:             sc_t = S;
            OP_SHL, OP_SHR: begin
               if (shamt == '0) sc_t = D;
               else             sc_multi = 1'b1;
            end
            OP_MUL:               sc_multi = 1'b1;
            default:              sc_zf_ok = 1'b0;
         endcase
      end
      sc_zf = sc_zf_ok && (sc_t == '0);
   end

   // One iteration of the running multi-cycle op; work_q holds the shift data or the multiplier.
   always_comb begin
      step_work = work_q;
      step_cf   = sh_cf_q;
      step_prod = prod_q;
      case (mop_q)
         MOP_SHL: {step_cf, step_work} = {work_q, 1'b0};
         MOP_SHR: {step_work, step_cf} = {1'b0, work_q};
         MOP_MUL: begin
            step_prod = work_q[0] ? (prod_q + mcand_q) : prod_q;
            step_work = work_q >> 1;
         end
         default: ;
      endcase
   end

   always_comb begin
      fin_t  = step_work;
      fin_cf = step_cf;
      if (mop_q == MOP_MUL) begin
         fin_t  = step_prod[WIDTH-1:0];
         fin_cf = |step_prod[2*WIDTH-1:WIDTH];
      end
   end

   always_comb begin
      state_d = state_q;
      mop_d   = mop_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      sh_cf_d = sh_cf_q;
      prod_d  = prod_q;
      mcand_d = mcand_q;
      t_d     = t_q;
      cf_d    = cf_q;
      zf_d    = zf_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (!sc_multi) begin
                  t_d    = sc_t;
                  cf_d   = sc_cf;
                  zf_d   = sc_zf;
                  done_d = 1'b1;
               end else if (se == OP_MUL) begin
                  state_d = ST_RUN;
                  mop_d   = MOP_MUL;
                  cnt_d   = CW'(WIDTH);
                  work_d  = S;
                  mcand_d = {{WIDTH{1'b0}}, D};
                  prod_d  = '0;
               end else begin
                  state_d = ST_RUN;
                  mop_d   = (se == OP_SHL) ? MOP_SHL : MOP_SHR;
                  cnt_d   = {1'b0, shamt};
                  work_d  = D;
                  sh_cf_d = 1'b0;
               end
            end
         end
         ST_RUN: begin
            cnt_d   = cnt_q - CW'(1);
            work_d  = step_work;
            sh_cf_d = step_cf;
            prod_d  = step_prod;
            mcand_d = mcand_q << 1;
            if (cnt_q == CW'(1)) begin
               state_d = ST_IDLE;
               t_d     = fin_t;
               cf_d    = fin_cf;
               zf_d    = (fin_t == '0);
               done_d  = 1'b1;
            end
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mop_q   <= MOP_SHL;
         cnt_q   <= '0;
         work_q  <= '0;
         sh_cf_q <= 1'b0;
         prod_q  <= '0;
         mcand_q <= '0;
         t_q     <= '0;
         cf_q    <= 1'b0;
         zf_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mop_q   <= mop_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         sh_cf_q <= sh_cf_d;
         prod_q  <= prod_d;
         mcand_q <= mcand_d;
         t_q     <= t_d;
         cf_q    <= cf_d;
         zf_q    <= zf_d;
         done_q  <= done_d;
      end
   end

   assign T    = t_q;
   assign Cf   = cf_q;
   assign Zf   = zf_q;
   assign busy = (state_q == ST_RUN);
   assign done = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases from the op table plus random ops
// compared against an arithmetic reference model.
module tb_alu_seq;

   localparam int W    = 8;
   localparam int MASK = (1 << W) - 1;

   logic         clk;
   logic         rst;
   logic         start;
   logic         m;
   logic [3:0]   se;
   logic [W-1:0] s;
   logic [W-1:0] d;
   logic [W-1:0] t;
   logic         cf;
   logic         zf;
   logic         busy;
   logic         done;

   int n_checks;
   int n_fail;

   int mdl_t;
   bit mdl_cf;
   bit mdl_zf;

   alu_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .M     (m),
      .se    (se),
      .S     (s),
      .D     (d),
      .T     (t),
      .Cf    (cf),
      .Zf    (zf),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: computes the result straight from the op table with integer arithmetic.
   function automatic void model(input bit mm, input int op, input int sv, input int dv,
                                 input bit cin, output int rt, output bit rcf,
                                 output bit rzf, output int lat);
      int     n;
      int     sum;
      longint p;
      bit     zf_ok;
      rt    = 0;
      rcf   = 1'b0;
      lat   = 0;
      zf_ok = 1'b1;
      n     = sv % W;
      if (!mm) begin
         rt = sv;
      end else begin
         case (op)
            9:  begin sum = sv + dv;       rt = sum & MASK; rcf = (sum > MASK); end
            6:  begin rt = (dv - sv) & MASK; rcf = (dv < sv); end
            1:  begin sum = sv + dv + int'(cin); rt = sum & MASK; rcf = (sum > MASK); end
            11: rt = sv & dv;
            8:  rt = sv | dv;
            5:  rt = (~dv) & MASK;
            10, 4: rt = dv;
            12: rt = sv;
            2: begin
               if (n == 0) rt = dv;
               else begin rt = (dv << n) & MASK; rcf = ((dv >> (W - n)) & 1) != 0; lat = n; end
            end
            3: begin
               if (n == 0) rt = dv;
               else begin rt = dv >> n; rcf = ((dv >> (n - 1)) & 1) != 0; lat = n; end
            end
            7: begin
               p   = longint'(sv) * longint'(dv);
               rt  = int'(p & MASK);
               rcf = (p >> W) != 0;
               lat = W;
            end
            default: zf_ok = 1'b0;
         endcase
      end
      rzf = zf_ok && (rt == 0);
   endfunction

   task automatic check_held(input string tag);
      check({tag, ".T_held"},  32'(t),  32'(mdl_t));
      check({tag, ".Cf_held"}, 32'(cf), 32'(mdl_cf));
      check({tag, ".Zf_held"}, 32'(zf), 32'(mdl_zf));
   endtask

   // Called at a negedge; issues one op and returns at the negedge after its completion edge.
   task automatic do_op(input string tag, input bit mm, input int op, input int sv,
                        input int dv, input bit pulse_mid);
      int rt;
      bit rcf;
      bit rzf;
      int lat;
      model(mm, op, sv, dv, mdl_cf, rt, rcf, rzf, lat);
      start = 1'b1;
      m     = mm;
      se    = 4'(op);
      s     = W'(sv);
      d     = W'(dv);
      @(negedge clk);
      start = 1'b0;
      s     = W'($urandom);
      d     = W'($urandom);
      se    = 4'($urandom);
      for (int j = 0; j < lat; j++) begin
         check({tag, ".busy"}, 32'(busy), 32'd1);
         check({tag, ".done_run"}, 32'(done), 32'd0);
         check_held(tag);
         if (pulse_mid && j == 1) begin
            start = 1'b1;
            m     = 1'b1;
            se    = 4'b1001;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      mdl_t  = rt;
      mdl_cf = rcf;
      mdl_zf = rzf;
      check({tag, ".T"},    32'(t),    32'(rt));
      check({tag, ".Cf"},   32'(cf),   32'(rcf));
      check({tag, ".Zf"},   32'(zf),   32'(rzf));
      check({tag, ".done"}, 32'(done), 32'd1);
      check({tag, ".busy_end"}, 32'(busy), 32'd0);
   endtask

   task automatic idle(input string tag);
      start = 1'b0;
      @(negedge clk);
      check({tag, ".done_drop"}, 32'(done), 32'd0);
      check_held(tag);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      mdl_t    = 0;
      mdl_cf   = 1'b0;
      mdl_zf   = 1'b0;
      rst      = 1'b1;
      start    = 1'b0;
      m        = 1'b0;
      se       = '0;
      s        = '0;
      d        = '0;
      #12;
      check("reset.T",    32'(t),    32'd0);
      check("reset.Cf",   32'(cf),   32'd0);
      check("reset.Zf",   32'(zf),   32'd0);
      check("reset.busy", 32'(busy), 32'd0);
      check("reset.done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      do_op("add80",  1'b1, 9, 8'h80, 8'h80, 1'b0);
      do_op("adc01",  1'b1, 1, 8'h01, 8'h01, 1'b0);
      check("adc01.const_T", 32'(t), 32'h03);
      idle("after_adc");
      do_op("sub_borrow", 1'b1, 6, 8'h07, 8'h05, 1'b0);
      check("sub_borrow.const_T", 32'(t), 32'hFE);
      do_op("sub_zero",   1'b1, 6, 8'h07, 8'h07, 1'b0);
      idle("after_sub");
      do_op("shl3",   1'b1, 2, 8'h03, 8'h81, 1'b1);
      check("shl3.const_T", 32'(t), 32'h08);
      do_op("shl0",   1'b1, 2, 8'h00, 8'h81, 1'b0);
      do_op("shr1",   1'b1, 3, 8'h01, 8'h81, 1'b0);
      do_op("shr7",   1'b1, 3, 8'h0F, 8'h80, 1'b1);
      do_op("mul1010", 1'b1, 7, 8'h10, 8'h10, 1'b1);
      do_op("mul0f03", 1'b1, 7, 8'h0F, 8'h03, 1'b0);
      check("mul0f03.const_T", 32'(t), 32'h2D);
      do_op("pass_s", 1'b0, int'($urandom_range(0, 15)), 8'h5A, 8'h33, 1'b0);
      do_op("undef",  1'b1, 15, 8'hFF, 8'hFF, 1'b0);
      do_op("undef_pass_s", 1'b1, 13, 8'h00, 8'h00, 1'b0);
      idle("after_undef");

      // Asynchronous reset while a multiply is running.
      do_op("pre_mul", 1'b1, 9, 8'h12, 8'h34, 1'b0);
      start = 1'b1;
      m     = 1'b1;
      se    = 4'b0111;
      s     = 8'hFF;
      d     = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mid.busy_before", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_mid.T",    32'(t),    32'd0);
      check("rst_mid.Cf",   32'(cf),   32'd0);
      check("rst_mid.Zf",   32'(zf),   32'd0);
      check("rst_mid.busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst    = 1'b0;
      mdl_t  = 0;
      mdl_cf = 1'b0;
      mdl_zf = 1'b0;
      for (int i = 0; i < W + 3; i++) begin
         @(negedge clk);
         check("rst_mid.no_done", 32'(done), 32'd0);
         check("rst_mid.no_busy", 32'(busy), 32'd0);
      end
      do_op("adc_after_rst", 1'b1, 1, 8'hFF, 8'h01, 1'b0);

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) idle("rnd_idle");
         do_op("rnd", ($urandom_range(0, 7) != 0), int'($urandom_range(0, 15)),
               int'($urandom & MASK), int'($urandom & MASK), ($urandom_range(0, 1) == 1));
      end
      idle("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
